// File: rtl/uv_intra_pred.sv
// uv_intra_pred: VP8 chroma intra predictor for one macroblock (U|V, 16x8).
// Captures the neighbours on start, computes the DC values in one cycle, then
// writes one 16-pixel row per cycle into the registered UVPred block.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start                   one-cycle job request (ignored while busy)
//   x, y                    macroblock position; 0 means that edge is missing
//   mode                    0=DC 1=TM 2=VE 3=HE
//   top_u/v, left_u/v       8 neighbour pixels per plane, pixel i at [8i+7:8i]
//   top_left_u/v            corner pixel per plane
//   UVPred                  pixel (r,c) at [128r+8c+7:128r+8c], U cols 0-7, V cols 8-15
//   busy                    high from the cycle after accept through done
//   done                    one-cycle pulse when UVPred is complete
module uv_intra_pred #(
  parameter int unsigned BLOCK_SIZE = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [9:0]                        x,
  input  logic [9:0]                        y,
  input  logic [1:0]                        mode,
  input  logic [BLOCK_SIZE*8-1:0]           top_u,
  input  logic [BLOCK_SIZE*8-1:0]           top_v,
  input  logic [BLOCK_SIZE*8-1:0]           left_u,
  input  logic [BLOCK_SIZE*8-1:0]           left_v,
  input  logic [7:0]                        top_left_u,
  input  logic [7:0]                        top_left_v,
  output logic [BLOCK_SIZE*BLOCK_SIZE*16-1:0] UVPred,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned PW    = 8;
  localparam int unsigned EDGE_W = BLOCK_SIZE * PW;
  localparam int unsigned ROW_W = 2 * EDGE_W;
  localparam int unsigned RW    = $clog2(BLOCK_SIZE);

  localparam logic [1:0] MODE_DC = 2'd0;
  localparam logic [1:0] MODE_TM = 2'd1;
  localparam logic [1:0] MODE_VE = 2'd2;

  typedef enum logic [1:0] {IDLE, SUM, ROW, FIN} state_t;

  state_t state_q, state_d;
  logic   busy_d, done_d, capture_c, sum_c, row_we_c;

  logic [1:0]        mode_q;
  logic              has_top_q, has_left_q;
  logic [EDGE_W-1:0] top_u_q, top_v_q, left_u_q, left_v_q;
  logic [7:0]        tl_u_q, tl_v_q, dc_u_q, dc_v_q;
  logic [RW-1:0]     r_q;

  logic [11:0]       sum_tu, sum_tv, sum_lu, sum_lv;
  logic [ROW_W-1:0]  row_c;

  // DC value from the available edge sums
  function automatic logic [7:0] dc_of(input logic ht, input logic hl,
                                       input logic [11:0] st, input logic [11:0] sl);
    logic [11:0] acc;
    acc = 12'd0;
    unique case ({ht, hl})
      2'b11:   acc = (st + sl + 12'd8) >> 4;
      2'b10:   acc = (st + 12'd4) >> 3;
      2'b01:   acc = (sl + 12'd4) >> 3;
      default: acc = 12'd128;
    endcase
    return acc[7:0];
  endfunction

  // One predicted pixel; TM falls back to VE/HE/129 when edges are missing
  function automatic logic [7:0] pix(input logic [1:0] m, input logic ht, input logic hl,
                                     input logic [7:0] t, input logic [7:0] l,
                                     input logic [7:0] tl, input logic [7:0] dc);
    logic signed [9:0] s;
    logic [7:0]        p;
    s = $signed({2'b00, t}) + $signed({2'b00, l}) - $signed({2'b00, tl});
    p = 8'd0;
    unique case (m)
      MODE_DC: p = dc;
      MODE_VE: p = ht ? t : 8'd127;
      MODE_TM: begin
        if (ht && hl) begin
          if (s < 10'sd0)        p = 8'd0;
          else if (s > 10'sd255) p = 8'd255;
          else                   p = s[7:0];
        end else if (hl) begin
          p = l;
        end else if (ht) begin
          p = t;
        end else begin
          p = 8'd129;
        end
      end
      default: p = hl ? l : 8'd129;
    endcase
    return p;
  endfunction

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    sum_c     = 1'b0;
    row_we_c  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        capture_c = 1'b1;
        state_d   = SUM;
      end
      SUM: begin
        sum_c   = 1'b1;
        state_d = ROW;
      end
      ROW: begin
        row_we_c = 1'b1;
        if (r_q == RW'(BLOCK_SIZE - 1)) state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // Edge sums for DC
  always_comb begin
    sum_tu = 12'd0;
    sum_tv = 12'd0;
    sum_lu = 12'd0;
    sum_lv = 12'd0;
    for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
      sum_tu = sum_tu + 12'(top_u_q[PW*i +: PW]);
      sum_tv = sum_tv + 12'(top_v_q[PW*i +: PW]);
      sum_lu = sum_lu + 12'(left_u_q[PW*i +: PW]);
      sum_lv = sum_lv + 12'(left_v_q[PW*i +: PW]);
    end
  end

  // Current row: U half then V half
  always_comb begin
    row_c = '0;
    for (int c = 0; c < int'(BLOCK_SIZE); c++) begin
      row_c[PW*c +: PW] = pix(mode_q, has_top_q, has_left_q, top_u_q[PW*c +: PW],
                              left_u_q[PW*r_q +: PW], tl_u_q, dc_u_q);
      row_c[EDGE_W + PW*c +: PW] = pix(mode_q, has_top_q, has_left_q, top_v_q[PW*c +: PW],
                                       left_v_q[PW*r_q +: PW], tl_v_q, dc_v_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_q        <= '0;
      UVPred     <= '0;
      mode_q     <= 2'd0;
      has_top_q  <= 1'b0;
      has_left_q <= 1'b0;
      top_u_q    <= '0;
      top_v_q    <= '0;
      left_u_q   <= '0;
      left_v_q   <= '0;
      tl_u_q     <= 8'd0;
      tl_v_q     <= 8'd0;
      dc_u_q     <= 8'd0;
      dc_v_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      if (capture_c) begin
        mode_q     <= mode;
        has_top_q  <= (y != 10'd0);
        has_left_q <= (x != 10'd0);
        top_u_q    <= top_u;
        top_v_q    <= top_v;
        left_u_q   <= left_u;
        left_v_q   <= left_v;
        tl_u_q     <= top_left_u;
        tl_v_q     <= top_left_v;
        r_q        <= '0;
      end
      if (sum_c) begin
        dc_u_q <= dc_of(has_top_q, has_left_q, sum_tu, sum_lu);
        dc_v_q <= dc_of(has_top_q, has_left_q, sum_tv, sum_lv);
      end
      if (row_we_c) begin
        UVPred[ROW_W*r_q +: ROW_W] <= row_c;
        r_q <= r_q + RW'(1);
      end
    end
  end

endmodule

// File: doc/uv_intra_pred.md
# uv_intra_pred

Chroma intra predictor for one macroblock. It builds the 16x8 U|V prediction block that `ReconstructUV` consumes on its `UVPred` input, using the top/left neighbour pixels and the macroblock position. It supports the four VP8 chroma modes (DC, TM, VE, HE) and emits the block row by row over 8 cycles into a registered output.

## Interface
Parameters:
- `BLOCK_SIZE`, 8: chroma plane edge in pixels; fixed at 8, other values unsupported.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle request; inputs are sampled on this cycle.
- `x`  in  10  macroblock column; left neighbours are available iff `x != 0`.
- `y`  in  10  macroblock row; top neighbours are available iff `y != 0`.
- `mode`  in  2  0=DC, 1=TM, 2=VE, 3=HE.
- `top_u`, `top_v`  in  64 each  row above the block; column c at bits [8c+7:8c].
- `left_u`, `left_v`  in  64 each  column left of the block; row r at bits [8r+7:8r].
- `top_left_u`, `top_left_v`  in  8 each  corner pixel.
- `UVPred`  out  1024  prediction block; pixel (r,c) at bits [128r+8c+7:128r+8c]. Columns 0-7 are U, columns 8-15 are V.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse; `UVPred` is complete and stable.

## Operation
- FSM states: IDLE, SUM, ROW, FIN.
- IDLE → SUM on `start`. Capture `mode`, the availability flags, and all neighbour pixels into internal registers.
- SUM (1 cycle) computes the DC value per plane:
  - both neighbours available: (Σtop8 + Σleft8 + 8) >> 4, using 12-bit sums;
  - top only: (Σtop8 + 4) >> 3;
  - left only: (Σleft8 + 4) >> 3;
  - neither: 128.
- ROW (8 cycles, 3-bit counter `r` = 0..7): write row `r` of `UVPred` (U and V halves together). Each pixel p at column c of a plane:
  - DC: p = dc of that plane.
  - VE: p = top[c] if top is available, else 127.
  - HE: p = left[r] if left is available, else 129.
  - TM, both available: p = clip255(top[c] + left[r] − top_left). Compute in 10-bit signed; clip to 0..255.
  - TM, left only: behaves as HE.
  - TM, top only: behaves as VE.
  - TM, neither: p = 129.
- ROW → FIN when `r` = 7. FIN asserts `done` for one cycle, then → IDLE.
- Rows not yet written in the current job keep their previous contents. Consumers read `UVPred` only at or after `done`.
- `start` while `busy` is ignored and does not affect the job in flight.
- Input changes after the `start` cycle have no effect, because all neighbours are captured.

## Timing
- `start` accepted at cycle T.
- SUM occupies T+1.
- Rows 0..7 are registered at the ends of cycles T+2..T+9.
- `done` is high during T+10, with all 8 rows valid.
- `busy` is high T+1..T+10.
- `start` at T+10 is not accepted; the earliest next accept is T+11. Throughput is one block per 11 cycles.
- Reset (async, any state): FSM → IDLE, `r` = 0, `UVPred` = 0, `busy` = 0, `done` = 0. A job interrupted by reset is discarded; no `done` is emitted.
- `done` goes low the cycle after FIN regardless of `start`.

## Test plan
- Reset mid-ROW (assert `rst_n`=0 at T+5) → `UVPred`=0, `busy`=0 immediately; no `done` is ever emitted for that job. After release, a new `start` completes normally at +10 cycles.
- DC, x=3, y=2, top_u all 10, left_u all 30, top_v all 200, left_v all 0 → every U pixel = 20, every V pixel = 100. `done` arrives exactly 10 cycles after `start`.
- DC, x=0, y=0 → all 128. DC, x=0, y=5, top_u = 0..7 → U = (28+4)>>3 = 4.
- TM, x=1, y=1, top_u[c]=250, left_u[r]=20, top_left_u=10 → U = 255 (clipped). Same with top_left_u=255, top=0, left=0 → U = 0 (clipped low).
- VE, y=0 → all 127. HE, x=0 → all 129. TM, x=0, y=1 → copies top per column. TM, x=2, y=0 → copies left per row.
- Back-to-back jobs: `start` pulsed every cycle for 30 cycles → exactly 3 `done` pulses, at T+10, T+21, T+32 relative to the first accept. Each job's `UVPred` matches the inputs captured at its accepting `start`.
